// File: rtl/move_commit_if.sv
// Request/response and board-read signals of the move_commit turn-execution block.
// slave is the move_commit side; master is the driving side.
interface move_commit_if #(
  parameter int unsigned CW = 4,
  parameter int unsigned NW = 9
);
  logic          place_req;
  logic [CW-1:0] place_x;
  logic [CW-1:0] place_y;
  logic [1:0]    color;
  logic          clear_board;
  logic          busy;
  logic          accept;
  logic          reject;
  logic          switch_turn;
  logic [CW-1:0] last_x;
  logic [CW-1:0] last_y;
  logic [NW-1:0] move_count;
  logic          board_full;
  logic [CW-1:0] rd_x;
  logic [CW-1:0] rd_y;
  logic [1:0]    rd_data;

  modport slave (
    input  place_req, place_x, place_y, color, clear_board, rd_x, rd_y,
    output busy, accept, reject, switch_turn, last_x, last_y, move_count,
           board_full, rd_data
  );

  modport master (
    output place_req, place_x, place_y, color, clear_board, rd_x, rd_y,
    input  busy, accept, reject, switch_turn, last_x, last_y, move_count,
           board_full, rd_data
  );
endinterface

// File: rtl/move_commit.sv
// Validates and commits a placement into the board store, then pulses switch_turn
// to the player-switch block. Owns the board memory and its combinational read port.
module move_commit #(
  parameter int unsigned BOARD_W = 16,
  parameter int unsigned BOARD_H = 16,
  parameter int unsigned CW      = 4,
  parameter int unsigned NW      = 9
) (
  input  logic        clk,
  input  logic        resetn,
  move_commit_if.slave bus
);

  localparam int unsigned CELLS = BOARD_W * BOARD_H;
  localparam int unsigned IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(CELLS);

  localparam logic [2:0] ST_CLEAR  = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_SWITCH = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic in_board(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return (32'(x) < BOARD_W) && (32'(y) < BOARD_H);
  endfunction

  // Out-of-board coordinates map to index 0 so the store is never overrun.
  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    if (!in_board(x, y)) return '0;
    return IW'(32'(y) * BOARD_W + 32'(x));
  endfunction

  logic [1:0]    mem_q [CELLS];

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;
  logic [CW-1:0] req_x_q, req_x_d;
  logic [CW-1:0] req_y_q, req_y_d;
  logic [1:0]    req_color_q, req_color_d;
  logic          accept_q, accept_d;
  logic          reject_q, reject_d;
  logic          switch_turn_q, switch_turn_d;
  logic [CW-1:0] last_x_q, last_x_d;
  logic [CW-1:0] last_y_q, last_y_d;
  logic [NW-1:0] move_count_q, move_count_d;

  logic          board_full;
  logic [IW-1:0] req_idx;
  logic          color_ok;
  logic          move_ok;
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [1:0]    mem_wdata;

  assign board_full = (move_count_q == FULL_CNT);
  assign req_idx    = cell_idx(req_x_q, req_y_q);
  assign color_ok   = (req_color_q == 2'b01) || (req_color_q == 2'b10);
  assign move_ok    = in_board(req_x_q, req_y_q) && color_ok &&
                      (mem_q[req_idx] == 2'b00) && !board_full;

  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    req_x_d       = req_x_q;
    req_y_d       = req_y_q;
    req_color_d   = req_color_q;
    accept_d      = 1'b0;
    reject_d      = 1'b0;
    switch_turn_d = 1'b0;
    last_x_d      = last_x_q;
    last_y_d      = last_y_q;
    move_count_d  = move_count_q;
    mem_we        = 1'b0;
    mem_waddr     = clr_idx_q;
    mem_wdata     = 2'b00;

    case (state_q)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        move_count_d = '0;
        last_x_d     = '0;
        last_y_d     = '0;
        if (clr_idx_q == LAST_IDX) begin
          clr_idx_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (bus.clear_board) begin
          clr_idx_d = '0;
          state_d   = ST_CLEAR;
        end else if (bus.place_req) begin
          req_x_d     = bus.place_x;
          req_y_d     = bus.place_y;
          req_color_d = bus.color;
          state_d     = ST_CHECK;
        end
      end

      // CHECK spans two cycles: the first commits or refuses, the second is the
      // cycle in which the accept/reject pulse is visible before moving on.
      ST_CHECK: begin
        if (accept_q || reject_q) begin
          switch_turn_d = accept_q;
          state_d       = accept_q ? ST_SWITCH : ST_IDLE;
        end else if (move_ok) begin
          mem_we       = 1'b1;
          mem_waddr    = req_idx;
          mem_wdata    = req_color_q;
          accept_d     = 1'b1;
          move_count_d = move_count_q + 1'b1;
          last_x_d     = req_x_q;
          last_y_d     = req_y_q;
        end else begin
          reject_d = 1'b1;
        end
      end

      ST_SWITCH: state_d = ST_DONE;

      ST_DONE: state_d = ST_IDLE;

      default: begin
        clr_idx_d = '0;
        state_d   = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_CLEAR;
      clr_idx_q     <= '0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      req_color_q   <= 2'b00;
      accept_q      <= 1'b0;
      reject_q      <= 1'b0;
      switch_turn_q <= 1'b0;
      last_x_q      <= '0;
      last_y_q      <= '0;
      move_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      req_color_q   <= req_color_d;
      accept_q      <= accept_d;
      reject_q      <= reject_d;
      switch_turn_q <= switch_turn_d;
      last_x_q      <= last_x_d;
      last_y_q      <= last_y_d;
      move_count_q  <= move_count_d;
    end
  end

  // Board store has no reset; the CLEAR sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    bus.rd_data = 2'b00;
    if (state_q != ST_CLEAR && in_board(bus.rd_x, bus.rd_y))
      bus.rd_data = mem_q[cell_idx(bus.rd_x, bus.rd_y)];
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.accept      = accept_q;
  assign bus.reject      = reject_q;
  assign bus.switch_turn = switch_turn_q;
  assign bus.last_x      = last_x_q;
  assign bus.last_y      = last_y_q;
  assign bus.move_count  = move_count_q;
  assign bus.board_full  = board_full;

endmodule
